mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port unified memory between the pipeline's IF stage
//  (instruction fetch) and MEM stage (load/store). Serialises accesses,
//  absorbs a fixed memory latency, and returns per-requester ready pulses.
//  The pipeline uses these pulses as its stall condition: a stage stalls
//  while its req=1 and its ready=0.
// PARAMETERS
//  AW       32  address width
//  DW       32  data width
//  MEM_LAT  2   memory access cycles, >=1; mem_rdata valid in last one
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   asynchronous, active-low reset (0 = reset)
//  if_req     in   1   fetch request, held until if_ready
//  if_addr    in   AW  fetch address
//  if_rdata   out  DW  fetched instruction, valid while if_ready=1
//  if_ready   out  1   1-cycle completion pulse to IF
//  dm_req     in   1   data request, held until dm_ready
//  dm_we      in   1   1 = store, 0 = load
//  dm_addr    in   AW  data address
//  dm_wdata   in   DW  store data
//  dm_rdata   out  DW  load data, valid while dm_ready=1
//  dm_ready   out  1   1-cycle completion pulse to MEM
//  mem_en     out  1   memory access enable
//  mem_we     out  1   memory write enable
//  mem_addr   out  AW  memory address
//  mem_wdata  out  DW  memory write data
//  mem_rdata  in   DW  memory read data
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE, cnt=0, last_grant=IF.
//    All outputs=0. Any in-flight access is abandoned; no ready pulse.
//  - FSM IDLE -> ACCESS -> RESP -> IDLE. Registered outputs only.
//  - IDLE: at a clock edge with any req=1, choose a grant:
//     - Only one req=1: that requester wins.
//     - Both req=1: the requester not equal to last_grant wins.
//       After reset this is DM.
//    On grant: latch addr, and for DM also we and wdata. Set last_grant,
//    cnt=MEM_LAT-1, go to ACCESS. With no req, stay in IDLE.
//  - ACCESS: mem_en=1. mem_addr/mem_we/mem_wdata come from the latch.
//    For IF grants mem_we=0 and mem_wdata=0.
//    Latched values are stable for all MEM_LAT cycles. cnt decrements each
//    cycle. At cnt==0, mem_rdata is captured into the granted rdata
//    register (not for stores) and the FSM goes to RESP.
//  - RESP: granted ready=1 for exactly one cycle and mem_en=0.
//    Next state is IDLE.
//  - Latency: req seen at edge N gives mem_en=1 for cycles N..N+MEM_LAT-1
//    and ready=1 in cycle N+MEM_LAT. Peak rate is one access per
//    MEM_LAT+2 cycles.
//  - rdata registers hold their value until the next load/fetch of that
//    requester. A store leaves dm_rdata unchanged.
//  - Requester changes or drops its req/addr mid-access: no effect. The
//    latched access completes and ready still pulses.
//  - if_ready and dm_ready are never both 1. mem_en is never 1 in IDLE or
//    RESP.
//  - Fairness: when both requesters stay asserted, grants alternate.
//    Neither requester waits more than one foreign access.
// TESTING
//  1 Reset: reset=0 mid-ACCESS -> all outputs 0 next sample, FSM IDLE,
//    no ready pulse after release.
//  2 Lone fetch: if_addr=0x0000_0040, memory returns 0x2008_0005 ->
//    mem_en high 2 cycles, if_ready 1 cycle later, if_rdata=0x2008_0005.
//  3 Store then load: dm_we=1, addr=0x100, wdata=0xDEAD_BEEF -> mem_we=1
//    for 2 cycles, dm_ready, dm_rdata unchanged. Load 0x100 ->
//    dm_rdata=0xDEAD_BEEF.
//  4 Contention: if_req and dm_req both held from reset -> grant order
//    DM, IF, DM, IF. Ready pulses 4 cycles apart (MEM_LAT=2). Never both
//    ready.
//  5 Req withdrawn: dm_req dropped 1 cycle after grant -> access
//    completes and dm_ready still pulses. Pending if_req is granted next.
//  6 MEM_LAT=1 build: lone fetch -> mem_en 1 cycle, if_ready in the
//    following cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch (IF) and
// load/store (DM) requesters; fixed-latency access with registered outputs.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ready,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int            CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          grant_dm_q, grant_dm_d;   // last grant: 1 = DM, 0 = IF
    logic          pick_dm;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          if_ready_q, if_ready_d;
    logic          dm_ready_q, dm_ready_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            grant_dm_q  <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grant_dm_q  <= grant_dm_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ready_q  <= if_ready_d;
            dm_ready_q  <= dm_ready_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grant_dm_d  = grant_dm_q;
        pick_dm     = 1'b0;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (if_req || dm_req) begin
                    // On contention the requester not served last time wins.
                    pick_dm    = dm_req && (!if_req || !grant_dm_q);
                    grant_dm_d = pick_dm;
                    cnt_d      = CNT_INIT;
                    state_d    = S_ACCESS;
                    mem_en_d   = 1'b1;
                    if (pick_dm) begin
                        mem_we_d    = dm_we;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                    end
                end
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d     = S_RESP;
                    mem_en_d    = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    if (grant_dm_q) begin
                        if (!mem_we_q) dm_rdata_d = mem_rdata;
                        dm_ready_d = 1'b1;
                    end else begin
                        if_rdata_d = mem_rdata;
                        if_ready_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_ready  = if_ready_q;
    assign dm_ready  = dm_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LAT=2 instance plus a MEM_LAT=1
// instance, both backed by a small word-addressed memory model.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [31:0] mem [0:255];

    logic        if_req, dm_req, dm_we, if_ready, dm_ready, mem_en, mem_we;
    logic [31:0] if_addr, dm_addr, dm_wdata, if_rdata, dm_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        if2_req, if2_ready, dm2_ready, mem2_en, mem2_we;
    logic [31:0] if2_addr, if2_rdata, dm2_rdata, mem2_addr, mem2_wdata, mem2_rdata;
    logic        dm2_req, dm2_we;
    logic [31:0] dm2_addr, dm2_wdata;

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(2)) dut (
        .clk(clk), .reset(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut_lat1 (
        .clk(clk), .reset(rst_n),
        .if_req(if2_req), .if_addr(if2_addr), .if_rdata(if2_rdata), .if_ready(if2_ready),
        .dm_req(dm2_req), .dm_we(dm2_we), .dm_addr(dm2_addr), .dm_wdata(dm2_wdata),
        .dm_rdata(dm2_rdata), .dm_ready(dm2_ready),
        .mem_en(mem2_en), .mem_we(mem2_we), .mem_addr(mem2_addr),
        .mem_wdata(mem2_wdata), .mem_rdata(mem2_rdata)
    );

    assign mem_rdata  = mem_en  ? mem[mem_addr[9:2]]  : 32'h0;
    assign mem2_rdata = mem2_en ? mem[mem2_addr[9:2]] : 32'h0;

    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr[9:2]] = mem_wdata;
    end

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL rst_mem_en got=%0h want=0", mem_en); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got=%0h want=0", mem_we); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rst_mem_addr got=%0h want=0", mem_addr); end
        total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_mem_wdata got=%0h want=0", mem_wdata); end
        total++; if (if_ready !== 1'b0 || dm_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0b%0b want=00", if_ready, dm_ready); end
        total++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%0h/%0h want=0/0", if_rdata, dm_rdata); end
        rst_n = 1'b1;
        // start a fetch, then pull reset in the middle of its access
        if_req = 1'b1; if_addr = 32'h40;
        @(negedge clk);
        total++; if (mem_en !== 1'b1) begin bad++; $display("FAIL rst_pre_access got=%0h want=1", mem_en); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL rst_async_en got=%0h want=0", mem_en); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rst_async_addr got=%0h want=0", mem_addr); end
        if_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++; if (if_ready !== 1'b0 || mem_en !== 1'b0) begin bad++; $display("FAIL rst_abandon c%0d got=rdy%0b en%0b want=rdy0 en0", k, if_ready, mem_en); end
        end
        total++; if (if_rdata !== 32'h0) begin bad++; $display("FAIL rst_abandon_rdata got=%0h want=0", if_rdata); end
    endtask

    task automatic test_lone_fetch();
        if_req = 1'b1; if_addr = 32'h0000_0040;
        @(negedge clk);
        total++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("FAIL fetch_c1 got=en%0b we%0b want=en1 we0", mem_en, mem_we); end
        total++; if (mem_addr !== 32'h40 || mem_wdata !== 32'h0) begin bad++; $display("FAIL fetch_c1_bus got=%0h/%0h want=40/0", mem_addr, mem_wdata); end
        total++; if (if_ready !== 1'b0) begin bad++; $display("FAIL fetch_c1_rdy got=%0b want=0", if_ready); end
        @(negedge clk);
        total++; if (mem_en !== 1'b1 || if_ready !== 1'b0) begin bad++; $display("FAIL fetch_c2 got=en%0b rdy%0b want=en1 rdy0", mem_en, if_ready); end
        @(negedge clk);
        total++; if (mem_en !== 1'b0 || if_ready !== 1'b1) begin bad++; $display("FAIL fetch_c3 got=en%0b rdy%0b want=en0 rdy1", mem_en, if_ready); end
        total++; if (if_rdata !== 32'h2008_0005) begin bad++; $display("FAIL fetch_rdata got=%0h want=20080005", if_rdata); end
        total++; if (dm_ready !== 1'b0) begin bad++; $display("FAIL fetch_dm_rdy got=%0b want=0", dm_ready); end
        if_req = 1'b0;
        @(negedge clk);
        total++; if (if_ready !== 1'b0 || mem_en !== 1'b0) begin bad++; $display("FAIL fetch_c4 got=rdy%0b en%0b want=0 0", if_ready, mem_en); end
        @(negedge clk);
    endtask

    task automatic test_store_load();
        // load preloaded word so dm_rdata holds a known non-zero value
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100; dm_wdata = 32'h0;
        repeat (3) @(negedge clk);
        total++; if (dm_ready !== 1'b1 || dm_rdata !== 32'h1111_2222) begin bad++; $display("FAIL load0 got=rdy%0b %0h want=rdy1 11112222", dm_ready, dm_rdata); end
        dm_req = 1'b0;
        repeat (2) @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin bad++; $display("FAIL store_c%0d got=en%0b we%0b want=en1 we1", k, mem_en, mem_we); end
            total++; if (mem_addr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL store_bus_c%0d got=%0h/%0h want=100/deadbeef", k, mem_addr, mem_wdata); end
        end
        @(negedge clk);
        total++; if (dm_ready !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("FAIL store_rdy got=rdy%0b we%0b want=rdy1 we0", dm_ready, mem_we); end
        total++; if (dm_rdata !== 32'h1111_2222) begin bad++; $display("FAIL store_keep got=%0h want=11112222", dm_rdata); end
        dm_req = 1'b0; dm_we = 1'b0;
        repeat (2) @(negedge clk);
        dm_req = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (dm_ready !== 1'b1 || dm_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL load1 got=rdy%0b %0h want=rdy1 deadbeef", dm_ready, dm_rdata); end
        dm_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_contention();
        logic        exp_dm [4];
        logic        want_dm, want_en;
        logic [31:0] want_addr;
        int          g, ph;
        exp_dm = '{1'b1, 1'b0, 1'b1, 1'b0};
        rst_n = 1'b0;
        if_req = 1'b1; if_addr = 32'h40;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            g = (k - 1) / 4; ph = (k - 1) % 4;
            want_dm   = exp_dm[g];
            want_en   = (ph < 2);
            want_addr = want_en ? (want_dm ? 32'h100 : 32'h40) : 32'h0;
            total++; if (mem_en !== want_en || mem_addr !== want_addr) begin bad++; $display("FAIL cont_bus c%0d got=en%0b %0h want=en%0b %0h", k, mem_en, mem_addr, want_en, want_addr); end
            total++; if (if_ready !== (ph == 2 && !want_dm) || dm_ready !== (ph == 2 && want_dm)) begin bad++; $display("FAIL cont_rdy c%0d got=if%0b dm%0b want=if%0b dm%0b", k, if_ready, dm_ready, (ph == 2 && !want_dm), (ph == 2 && want_dm)); end
            if (ph == 2) begin
                total++; if (want_dm ? (dm_rdata !== 32'hDEAD_BEEF) : (if_rdata !== 32'h2008_0005)) begin bad++; $display("FAIL cont_rdata c%0d got=%0h/%0h want_dm=%0b", k, if_rdata, dm_rdata, want_dm); end
            end
        end
        if_req = 1'b0; dm_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_withdraw();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
        @(negedge clk);
        total++; if (mem_en !== 1'b1 || mem_addr !== 32'h100) begin bad++; $display("FAIL wd_c1 got=en%0b %0h want=en1 100", mem_en, mem_addr); end
        dm_req = 1'b0; dm_addr = 32'h200;
        if_req = 1'b1; if_addr = 32'h40;
        @(negedge clk);
        total++; if (mem_en !== 1'b1 || mem_addr !== 32'h100) begin bad++; $display("FAIL wd_c2 got=en%0b %0h want=en1 100", mem_en, mem_addr); end
        @(negedge clk);
        total++; if (dm_ready !== 1'b1 || if_ready !== 1'b0 || dm_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wd_rdy got=dm%0b if%0b %0h want=dm1 if0 deadbeef", dm_ready, if_ready, dm_rdata); end
        @(negedge clk);
        total++; if (mem_en !== 1'b0 || dm_ready !== 1'b0) begin bad++; $display("FAIL wd_c4 got=en%0b rdy%0b want=0 0", mem_en, dm_ready); end
        @(negedge clk);
        total++; if (mem_en !== 1'b1 || mem_addr !== 32'h40) begin bad++; $display("FAIL wd_if_grant got=en%0b %0h want=en1 40", mem_en, mem_addr); end
        repeat (2) @(negedge clk);
        total++; if (if_ready !== 1'b1 || dm_ready !== 1'b0) begin bad++; $display("FAIL wd_if_rdy got=if%0b dm%0b want=if1 dm0", if_ready, dm_ready); end
        if_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_lat1();
        if2_req = 1'b1; if2_addr = 32'h40;
        @(negedge clk);
        total++; if (mem2_en !== 1'b1 || mem2_addr !== 32'h40 || mem2_we !== 1'b0) begin bad++; $display("FAIL lat1_c1 got=en%0b %0h we%0b want=en1 40 we0", mem2_en, mem2_addr, mem2_we); end
        total++; if (if2_ready !== 1'b0) begin bad++; $display("FAIL lat1_c1_rdy got=%0b want=0", if2_ready); end
        @(negedge clk);
        total++; if (mem2_en !== 1'b0 || if2_ready !== 1'b1) begin bad++; $display("FAIL lat1_c2 got=en%0b rdy%0b want=en0 rdy1", mem2_en, if2_ready); end
        total++; if (if2_rdata !== 32'h2008_0005) begin bad++; $display("FAIL lat1_rdata got=%0h want=20080005", if2_rdata); end
        if2_req = 1'b0;
        @(negedge clk);
        total++; if (if2_ready !== 1'b0 || dm2_ready !== 1'b0) begin bad++; $display("FAIL lat1_c3 got=if%0b dm%0b want=0 0", if2_ready, dm2_ready); end
        total++; if (dm2_rdata !== 32'h0 || mem2_wdata !== 32'h0) begin bad++; $display("FAIL lat1_idle_data got=%0h/%0h want=0/0", dm2_rdata, mem2_wdata); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = 32'h2008_0005;
        mem[8'h40] = 32'h1111_2222;
        if_req = 1'b0; if_addr = 32'h0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0;
        if2_req = 1'b0; if2_addr = 32'h0;
        dm2_req = 1'b0; dm2_we = 1'b0; dm2_addr = 32'h0; dm2_wdata = 32'h0;
        test_reset();
        test_lone_fetch();
        test_store_load();
        test_contention();
        test_withdraw();
        test_lat1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
